// File: rtl/cpu_eu_pkg.sv
// Shared definitions for the self-sequencing execution unit: opcodes,
// sequencer state encoding and flag bit positions.
package cpu_eu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_LDI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JC   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_RST_WAIT,
    ST_FETCH,
    ST_DECODE,
    ST_MEM,
    ST_IMM,
    ST_HALT
  } state_e;

  // Flag register is packed {C,N,Z}.
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_MOV;
  endfunction

endpackage

// File: rtl/cpu_eu_alu.sv
// Combinational ALU for opcodes ADD..MOV; c_o is carry, borrow or the
// bit shifted out, and is cleared by the logical ops and MOV.
module cpu_eu_alu
  import cpu_eu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] r_i,
  input  logic [DW-1:0] s_i,
  input  logic [3:0]    op_i,
  output logic [DW-1:0] result_o,
  output logic          c_o,
  output logic          n_o,
  output logic          z_o
);

  always_comb begin
    result_o = '0;
    c_o      = 1'b0;
    case (op_i)
      OP_ADD: {c_o, result_o} = {1'b0, r_i} + {1'b0, s_i};
      OP_SUB: begin
        result_o = r_i - s_i;
        c_o      = (r_i < s_i);
      end
      OP_AND: result_o = r_i & s_i;
      OP_OR:  result_o = r_i | s_i;
      OP_XOR: result_o = r_i ^ s_i;
      OP_NOT: result_o = ~s_i;
      OP_SHL: begin
        result_o = {s_i[DW-2:0], 1'b0};
        c_o      = s_i[DW-1];
      end
      OP_SHR: begin
        result_o = {1'b0, s_i[DW-1:1]};
        c_o      = s_i[0];
      end
      OP_MOV: result_o = s_i;
      default: ;
    endcase
    n_o = result_o[DW-1];
    z_o = (result_o == '0);
  end

endmodule

// File: rtl/cpu_eu_seq.sv
// Execution unit with its own fetch/decode/execute sequencer, inline
// register file and a single req/rdy memory port.
module cpu_eu_seq
  import cpu_eu_pkg::*;
#(
  parameter int              DW       = 16,
  parameter int              NREG     = 8,
  parameter logic [DW-1:0]   PC_RESET = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] D_in,
  input  logic          mem_rdy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] Address,
  output logic [DW-1:0] D_out,
  output logic          C,
  output logic          N,
  output logic          Z,
  output logic [DW-1:0] pc_out,
  output logic [DW-1:0] ir_out,
  output logic          halted,
  output state_e        dbg_state_o
);

  localparam int RA = $clog2(NREG);

  if (DW < 16 || NREG < 2 || NREG != (1 << RA) || 4 + 3 * RA > DW) begin : g_bad_params
    $error("cpu_eu_seq: DW=%0d too narrow for NREG=%0d, or NREG not a power of 2", DW, NREG);
  end

  state_e        state_q, state_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [2:0]    flags_q, flags_d;
  logic [DW-1:0] addr_hold_q, addr_hold_d;
  logic [DW-1:0] data_hold_q, data_hold_d;
  logic [DW-1:0] rf_q [NREG];

  logic          rf_we;
  logic [RA-1:0] rf_wa;
  logic [DW-1:0] rf_wd;

  logic [3:0]    op;
  logic [RA-1:0] w_f, r_f, s_f;
  logic [DW-1:0] r_val, s_val, alu_res;
  logic          alu_c, alu_n, alu_z;

  assign op    = ir_q[DW-1:DW-4];
  assign w_f   = ir_q[3*RA-1:2*RA];
  assign r_f   = ir_q[2*RA-1:RA];
  assign s_f   = ir_q[RA-1:0];
  assign r_val = rf_q[r_f];
  assign s_val = rf_q[s_f];

  cpu_eu_alu #(.DW(DW)) u_alu (
    .r_i      (r_val),
    .s_i      (s_val),
    .op_i     (op),
    .result_o (alu_res),
    .c_o      (alu_c),
    .n_o      (alu_n),
    .z_o      (alu_z)
  );

  // Handshake: mem_req is a pure decode of state; Address, D_out and mem_we
  // come from registered values, so they hold steady while mem_req is high
  // until the cycle mem_rdy is seen, which completes the transfer.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    flags_d     = flags_q;
    addr_hold_d = addr_hold_q;
    data_hold_d = data_hold_q;
    rf_we       = 1'b0;
    rf_wa       = w_f;
    rf_wd       = alu_res;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    Address     = pc_q;
    D_out       = '0;
    case (state_q)
      ST_RST_WAIT: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          ir_d    = D_in;
          pc_d    = pc_q + DW'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d     = ST_FETCH;
        addr_hold_d = r_val;
        data_hold_d = s_val;
        if (is_alu_op(op)) begin
          rf_we           = 1'b1;
          flags_d[FLAG_C] = alu_c;
          flags_d[FLAG_N] = alu_n;
          flags_d[FLAG_Z] = alu_z;
        end else begin
          case (op)
            OP_JMP:       pc_d = r_val;
            OP_JZ:        if (flags_q[FLAG_Z]) pc_d = r_val;
            OP_JC:        if (flags_q[FLAG_C]) pc_d = r_val;
            OP_LD, OP_ST: state_d = ST_MEM;
            OP_LDI:       state_d = ST_IMM;
            OP_HALT:      state_d = ST_HALT;
            default: ;
          endcase
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op == OP_ST);
        Address = addr_hold_q;
        D_out   = data_hold_q;
        if (mem_rdy) begin
          rf_we   = (op == OP_LD);
          rf_wd   = D_in;
          state_d = ST_FETCH;
        end
      end
      ST_IMM: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          rf_we   = 1'b1;
          rf_wd   = D_in;
          pc_d    = pc_q + DW'(1);
          state_d = ST_FETCH;
        end
      end
      ST_HALT: ;
      default: state_d = ST_RST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RST_WAIT;
      pc_q        <= PC_RESET;
      ir_q        <= '0;
      flags_q     <= '0;
      addr_hold_q <= '0;
      data_hold_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      flags_q     <= flags_d;
      addr_hold_q <= addr_hold_d;
      data_hold_q <= data_hold_d;
      if (rf_we) rf_q[rf_wa] <= rf_wd;
    end
  end

  assign C           = flags_q[FLAG_C];
  assign N           = flags_q[FLAG_N];
  assign Z           = flags_q[FLAG_Z];
  assign pc_out      = pc_q;
  assign ir_out      = ir_q;
  assign halted      = (state_q == ST_HALT);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cpu_eu_seq.sv
// Directed bench for cpu_eu_seq: a 16-bit unit running the main program,
// a 16-bit unit with PC wrap at reset, and a 32-bit/16-register unit.
module tb_cpu_eu_seq;
  import cpu_eu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_w, rst_b;
  logic rdy_a, rdy_w, rdy_b;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- DUT A: DW=16, NREG=8, PC_RESET=0 ----------------
  logic [15:0] din_a, addr_a, dout_a, pc_a, ir_a;
  logic        req_a, we_a, c_a, n_a, z_a, halt_a;
  state_e      st_a;
  logic [15:0] mem_a [65536];
  assign din_a = mem_a[addr_a];

  cpu_eu_seq #(.DW(16), .NREG(8), .PC_RESET(16'h0000)) dut_a (
    .clk(clk), .reset(rst_a), .D_in(din_a), .mem_rdy(rdy_a),
    .mem_req(req_a), .mem_we(we_a), .Address(addr_a), .D_out(dout_a),
    .C(c_a), .N(n_a), .Z(z_a), .pc_out(pc_a), .ir_out(ir_a),
    .halted(halt_a), .dbg_state_o(st_a)
  );

  // ---------------- DUT W: DW=16, PC_RESET=0xFFFF ----------------
  logic [15:0] din_w, addr_w, dout_w, pc_w, ir_w;
  logic        req_w, we_w, c_w, n_w, z_w, halt_w;
  state_e      st_w;
  assign din_w = (addr_w == 16'hFFFF) ? 16'h8000 : 16'hF000;  // MOV R0,R0 then HALT

  cpu_eu_seq #(.DW(16), .NREG(8), .PC_RESET(16'hFFFF)) dut_w (
    .clk(clk), .reset(rst_w), .D_in(din_w), .mem_rdy(rdy_w),
    .mem_req(req_w), .mem_we(we_w), .Address(addr_w), .D_out(dout_w),
    .C(c_w), .N(n_w), .Z(z_w), .pc_out(pc_w), .ir_out(ir_w),
    .halted(halt_w), .dbg_state_o(st_w)
  );

  // ---------------- DUT B: DW=32, NREG=16 ----------------
  logic [31:0] din_b, addr_b, dout_b, pc_b, ir_b;
  logic        req_b, we_b, c_b, n_b, z_b, halt_b;
  state_e      st_b;
  logic [31:0] mem_b [65536];
  assign din_b = mem_b[addr_b[15:0]];

  cpu_eu_seq #(.DW(32), .NREG(16), .PC_RESET(32'h0)) dut_b (
    .clk(clk), .reset(rst_b), .D_in(din_b), .mem_rdy(rdy_b),
    .mem_req(req_b), .mem_we(we_b), .Address(addr_b), .D_out(dout_b),
    .C(c_b), .N(n_b), .Z(z_b), .pc_out(pc_b), .ir_out(ir_b),
    .halted(halt_b), .dbg_state_o(st_b)
  );

  // ---------------- scoreboard: expected memory writes ----------------
  logic [31:0] exp_a [$];   // {addr16, data16}
  logic [63:0] exp_b [$];   // {addr32, data32}
  logic [31:0] e_a;
  logic [63:0] e_b;

  always @(posedge clk) begin
    if (req_a && rdy_a && we_a) begin
      mem_a[addr_a] <= dout_a;
      n_tests++;
      if (exp_a.size() == 0) begin
        n_fail++;
        $error("FAIL wr_a: unexpected write addr=%h data=%h", addr_a, dout_a);
      end else begin
        e_a = exp_a.pop_front();
        assert ({addr_a, dout_a} === e_a) else begin
          n_fail++;
          $error("FAIL wr_a: got %h expected %h", {addr_a, dout_a}, e_a);
        end
      end
    end
    if (req_b && rdy_b && we_b) begin
      mem_b[addr_b[15:0]] <= dout_b;
      n_tests++;
      if (exp_b.size() == 0) begin
        n_fail++;
        $error("FAIL wr_b: unexpected write addr=%h data=%h", addr_b, dout_b);
      end else begin
        e_b = exp_b.pop_front();
        assert ({addr_b, dout_b} === e_b) else begin
          n_fail++;
          $error("FAIL wr_b: got %h expected %h", {addr_b, dout_b}, e_b);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] e16(input logic [3:0] op, input logic [2:0] w, r, s);
    return {op, 3'b000, w, r, s};
  endfunction

  function automatic logic [31:0] e32(input logic [3:0] op, input logic [3:0] w, r, s);
    return {op, 16'h0000, w, r, s};
  endfunction

  function automatic state_e st_of(input int which);
    return (which == 0) ? st_a : ((which == 1) ? st_b : st_w);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // From the first cycle of a FETCH (rdy high), run to the next FETCH entry.
  task automatic step(input int which, input int exp_cyc, input string tag);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (st_of(which) == ST_FETCH && cyc < 50);
    while (st_of(which) != ST_FETCH && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_a = 1'b1; rst_w = 1'b1; rst_b = 1'b1;
    rdy_a = 1'b0; rdy_w = 1'b0; rdy_b = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 32'h0;
    end

    mem_a[0]  = e16(OP_LDI, 1, 0, 0); mem_a[1]  = 16'h7FFF;
    mem_a[2]  = e16(OP_LDI, 2, 0, 0); mem_a[3]  = 16'h0001;
    mem_a[4]  = e16(OP_ADD, 3, 1, 2);
    mem_a[5]  = e16(OP_LDI, 4, 0, 0); mem_a[6]  = 16'hFFFF;
    mem_a[7]  = e16(OP_ADD, 5, 4, 2);
    mem_a[8]  = e16(OP_LDI, 7, 0, 0); mem_a[9]  = 16'h0040;
    mem_a[10] = e16(OP_ST,  0, 7, 3);
    mem_a[11] = e16(OP_LD,  6, 7, 0);
    mem_a[12] = e16(OP_LDI, 0, 0, 0); mem_a[13] = 16'h0041;
    mem_a[14] = e16(OP_ST,  0, 0, 6);
    mem_a[15] = e16(OP_ST,  0, 0, 5);
    mem_a[16] = e16(OP_JZ,  0, 1, 0);
    mem_a[16'h7FFF] = e16(OP_LDI, 4, 0, 0); mem_a[16'h8000] = 16'h0002;
    mem_a[16'h8001] = e16(OP_SUB, 3, 2, 4);
    mem_a[16'h8002] = e16(OP_ST,  0, 7, 3);
    mem_a[16'h8003] = e16(OP_AND, 5, 1, 6); mem_a[16'h8004] = e16(OP_ST, 0, 7, 5);
    mem_a[16'h8005] = e16(OP_OR,  5, 1, 6); mem_a[16'h8006] = e16(OP_ST, 0, 7, 5);
    mem_a[16'h8007] = e16(OP_XOR, 5, 3, 1); mem_a[16'h8008] = e16(OP_ST, 0, 7, 5);
    mem_a[16'h8009] = e16(OP_NOT, 5, 0, 2); mem_a[16'h800A] = e16(OP_ST, 0, 7, 5);
    mem_a[16'h800B] = e16(OP_SHL, 5, 0, 6); mem_a[16'h800C] = e16(OP_ST, 0, 7, 5);
    mem_a[16'h800D] = e16(OP_SHR, 5, 0, 3); mem_a[16'h800E] = e16(OP_ST, 0, 7, 5);
    mem_a[16'h800F] = e16(OP_MOV, 5, 0, 4); mem_a[16'h8010] = e16(OP_ST, 0, 7, 5);
    mem_a[16'h8011] = e16(OP_JC,  0, 7, 0);
    mem_a[16'h8012] = e16(OP_HALT, 0, 0, 0);

    mem_b[0]  = e32(OP_LDI, 9, 0, 0);  mem_b[1]  = 32'h7FFF_FFFF;
    mem_b[2]  = e32(OP_LDI, 10, 0, 0); mem_b[3]  = 32'h0000_0001;
    mem_b[4]  = e32(OP_ADD, 11, 9, 10);
    mem_b[5]  = e32(OP_LDI, 12, 0, 0); mem_b[6]  = 32'hFFFF_FFFF;
    mem_b[7]  = e32(OP_ADD, 13, 12, 10);
    mem_b[8]  = e32(OP_LDI, 15, 0, 0); mem_b[9]  = 32'h0000_0040;
    mem_b[10] = e32(OP_ST,  0, 15, 11);
    mem_b[11] = e32(OP_ST,  0, 15, 13);
    mem_b[12] = e32(OP_JZ,  0, 9, 0);
    mem_b[16'hFFFF] = e32(OP_HALT, 0, 0, 0);

    // Reset values and reset abandoning a stalled fetch.
    repeat (2) @(negedge clk);
    chk("rst_req",   64'(req_a), 64'd0);
    chk("rst_we",    64'(we_a), 64'd0);
    chk("rst_addr",  64'(addr_a), 64'h0);
    chk("rst_dout",  64'(dout_a), 64'h0);
    chk("rst_pc",    64'(pc_a), 64'h0);
    chk("rst_ir",    64'(ir_a), 64'h0);
    chk("rst_flags", 64'({c_a, n_a, z_a}), 64'd0);
    chk("rst_halt",  64'(halt_a), 64'd0);
    rst_a = 1'b0;
    chk("rel_req0", 64'(req_a), 64'd0);
    @(negedge clk);
    chk("fetch_req", 64'(req_a), 64'd1);
    chk("fetch_addr", 64'(addr_a), 64'h0);
    repeat (2) @(negedge clk);
    chk("stall_pc", 64'(pc_a), 64'h0);
    #2 rst_a = 1'b1;
    #1;
    chk("midrst_req", 64'(req_a), 64'd0);
    chk("midrst_pc", 64'(pc_a), 64'h0);
    chk("midrst_flags", 64'({c_a, n_a, z_a}), 64'd0);
    @(negedge clk);
    rst_a = 1'b0;
    chk("rel2_req0", 64'(req_a), 64'd0);
    @(negedge clk);
    chk("rel2_req1", 64'(req_a), 64'd1);
    rdy_a = 1'b1;

    // LDI / ADD with sign and carry results.
    step(0, 3, "ldi_r1");
    step(0, 3, "ldi_r2");
    step(0, 2, "add_r3");
    chk("add_r3_flags", 64'({c_a, n_a, z_a}), 64'b010);
    step(0, 3, "ldi_r4");
    step(0, 2, "add_r5");
    chk("add_r5_flags", 64'({c_a, n_a, z_a}), 64'b101);
    step(0, 3, "ldi_r7");

    // ST [R7],R3 observed cycle by cycle.
    exp_a.push_back({16'h0040, 16'h8000});
    @(negedge clk);
    chk("st_dec_req", 64'(req_a), 64'd0);
    @(negedge clk);
    chk("st_mem_req", 64'(req_a), 64'd1);
    chk("st_mem_we", 64'(we_a), 64'd1);
    chk("st_mem_addr", 64'(addr_a), 64'h0040);
    chk("st_mem_dout", 64'(dout_a), 64'h8000);
    @(negedge clk);
    chk("st_back_fetch", 64'(st_a), 64'(ST_FETCH));
    chk("st_dout_idle", 64'(dout_a), 64'h0);

    step(0, 3, "ld_r6");
    chk("ld_flags_held", 64'({c_a, n_a, z_a}), 64'b101);
    step(0, 3, "ldi_r0");
    exp_a.push_back({16'h0041, 16'h8000});
    step(0, 3, "st_r6");
    exp_a.push_back({16'h0041, 16'h0000});
    step(0, 3, "st_r5");
    chk("st_flags_held", 64'({c_a, n_a, z_a}), 64'b101);
    step(0, 2, "jz_taken");
    chk("jz_addr", 64'(addr_a), 64'h7FFF);
    chk("jz_pc", 64'(pc_a), 64'h7FFF);

    step(0, 3, "ldi_r4b");
    step(0, 2, "sub");
    chk("sub_flags", 64'({c_a, n_a, z_a}), 64'b110);

    // Three stall cycles in FETCH and three in MEM for ST [R7],R3.
    exp_a.push_back({16'h0040, 16'hFFFF});
    begin
      int cyc;
      cyc = 0;
      rdy_a = 1'b0;
      repeat (3) begin
        @(negedge clk);
        cyc++;
        chk("fstall_addr", 64'(addr_a), 64'h8002);
        chk("fstall_req", 64'(req_a), 64'd1);
        chk("fstall_we", 64'(we_a), 64'd0);
        chk("fstall_pc", 64'(pc_a), 64'h8002);
      end
      rdy_a = 1'b1;
      @(negedge clk);
      cyc++;
      chk("fstall_pc_adv", 64'(pc_a), 64'h8003);
      rdy_a = 1'b0;
      @(negedge clk);
      cyc++;
      repeat (3) begin
        chk("mstall_addr", 64'(addr_a), 64'h0040);
        chk("mstall_dout", 64'(dout_a), 64'hFFFF);
        chk("mstall_we", 64'(we_a), 64'd1);
        chk("mstall_req", 64'(req_a), 64'd1);
        @(negedge clk);
        cyc++;
      end
      rdy_a = 1'b1;
      @(negedge clk);
      cyc++;
      chk("stall_total_state", 64'(st_a), 64'(ST_FETCH));
      chk("stall_total_cycles", 64'(cyc), 64'd9);
    end

    step(0, 2, "and");
    chk("and_flags", 64'({c_a, n_a, z_a}), 64'b001);
    exp_a.push_back({16'h0040, 16'h0000});
    step(0, 3, "st_and");
    step(0, 2, "or");
    chk("or_flags", 64'({c_a, n_a, z_a}), 64'b010);
    exp_a.push_back({16'h0040, 16'hFFFF});
    step(0, 3, "st_or");
    step(0, 2, "xor");
    chk("xor_flags", 64'({c_a, n_a, z_a}), 64'b010);
    exp_a.push_back({16'h0040, 16'h8000});
    step(0, 3, "st_xor");
    step(0, 2, "not");
    chk("not_flags", 64'({c_a, n_a, z_a}), 64'b010);
    exp_a.push_back({16'h0040, 16'hFFFE});
    step(0, 3, "st_not");
    step(0, 2, "shl");
    chk("shl_flags", 64'({c_a, n_a, z_a}), 64'b101);
    exp_a.push_back({16'h0040, 16'h0000});
    step(0, 3, "st_shl");
    step(0, 2, "shr");
    chk("shr_flags", 64'({c_a, n_a, z_a}), 64'b100);
    exp_a.push_back({16'h0040, 16'h7FFF});
    step(0, 3, "st_shr");
    step(0, 2, "mov");
    chk("mov_flags", 64'({c_a, n_a, z_a}), 64'b000);
    exp_a.push_back({16'h0040, 16'h0002});
    step(0, 3, "st_mov");
    step(0, 2, "jc_not_taken");
    chk("jc_pc", 64'(pc_a), 64'h8012);

    // HALT: no further requests even with rdy high.
    repeat (2) @(negedge clk);
    chk("halted", 64'(halt_a), 64'd1);
    repeat (20) begin
      @(negedge clk);
      chk("halt_req", 64'(req_a), 64'd0);
    end
    chk("exp_a_drained", 64'(exp_a.size()), 64'd0);

    // PC wrap from 0xFFFF.
    rst_w = 1'b0;
    rdy_w = 1'b1;
    chk("w_rst_addr", 64'(addr_w), 64'hFFFF);
    @(negedge clk);
    chk("w_fetch_addr", 64'(addr_w), 64'hFFFF);
    step(2, 2, "w_mov");
    chk("w_wrap_addr", 64'(addr_w), 64'h0000);
    chk("w_wrap_pc", 64'(pc_w), 64'h0000);

    // 32-bit, 16-register unit.
    rst_b = 1'b0;
    @(negedge clk);
    rdy_b = 1'b1;
    step(1, 3, "b_ldi_r9");
    step(1, 3, "b_ldi_r10");
    step(1, 2, "b_add_r11");
    chk("b_add_r11_flags", 64'({c_b, n_b, z_b}), 64'b010);
    step(1, 3, "b_ldi_r12");
    step(1, 2, "b_add_r13");
    chk("b_add_r13_flags", 64'({c_b, n_b, z_b}), 64'b101);
    step(1, 3, "b_ldi_r15");
    exp_b.push_back({32'h0000_0040, 32'h8000_0000});
    step(1, 3, "b_st_r11");
    exp_b.push_back({32'h0000_0040, 32'h0000_0000});
    step(1, 3, "b_st_r13");
    step(1, 2, "b_jz");
    chk("b_jz_addr", 64'(addr_b), 64'h7FFF_FFFF);
    repeat (2) @(negedge clk);
    chk("b_halted", 64'(halt_b), 64'd1);
    chk("exp_b_drained", 64'(exp_b.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
